// File: rtl/somador_subtrator_serial_pkg.sv
// Shared types for the bit-serial adder/subtractor: FSM state encoding and op codes.
package somador_subtrator_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/somadorcompleto.sv
// One-bit full-adder cell with the carry registered between cycles.
// load seeds the carry at accept time; en advances it once per processed bit.
module somadorcompleto (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic c_init,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c_in,
  output logic c_out
);

  logic c_q, c_d;

  assign c_in  = c_q;
  assign s     = a ^ b ^ c_q;
  assign c_out = (a & b) | (a & c_q) | (b & c_q);

  always_comb begin
    c_d = c_q;
    if (load) begin
      c_d = c_init;
    end else if (en) begin
      c_d = c_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= 1'b0;
    end else begin
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/somador_subtrator_serial.sv
// Bit-serial add/subtract, LSB first, one bit per cycle; result appears WIDTH edges after accept.
// The operand A register doubles as the result shift register: sums enter at the MSB as A bits leave.
module somador_subtrator_serial
  import somador_subtrator_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             fa_s, fa_cin, fa_cout;
  logic [WIDTH-1:0] shifted_a;

  assign accept    = (state_q == IDLE) && start;
  assign shifted_a = {fa_s, a_q[WIDTH-1:1]};

  // Subtraction feeds ~b with the carry seeded to ~cin, so a borrow-in becomes a missing +1.
  somadorcompleto u_fa (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .c_init ((op == OP_ADD) ? cin : ~cin),
    .en     (state_q == RUN),
    .a      (a_q[0]),
    .b      (b_q[0] ^ (op_q == OP_SUB)),
    .s      (fa_s),
    .c_in   (fa_cin),
    .c_out  (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          s_d     = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
        end
      end
      RUN: begin
        a_d   = shifted_a;
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          s_d     = shifted_a;
          cout_d  = fa_cout ^ (op_q == OP_SUB);
          ovf_d   = fa_cin ^ fa_cout;
          zero_d  = (shifted_a == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign s     = s_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// Directed vectors on an 8-bit instance plus an exhaustive back-to-back sweep on a 4-bit instance.
module tb_somador_subtrator_serial;
  import somador_subtrator_serial_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0, op8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       ready8, cout8, ovf8, zero8, done8;

  logic       start4 = 1'b0, op4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       ready4, cout4, ovf4, zero4, done4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  somador_subtrator_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .cin(cin8), .a(a8), .b(b8),
    .ready(ready8), .s(s8), .cout(cout8), .ovf(ovf8), .zero(zero8), .done(done8)
  );

  somador_subtrator_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .cin(cin4), .a(a4), .b(b4),
    .ready(ready4), .s(s4), .cout(cout4), .ovf(ovf4), .zero(zero4), .done(done4)
  );

  typedef struct {
    logic       op;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Independent reference: plain integer arithmetic and sign-rule overflow.
  function automatic res_t ref_model(input int w, input logic o, input logic c,
                                     input logic [7:0] x, input logic [7:0] y);
    logic [8:0] t;
    logic [7:0] mask, yy;
    res_t r;
    mask   = 8'((9'd1 << w) - 9'd1);
    yy     = o ? (~y & mask) : y;
    t      = {1'b0, x} + {1'b0, yy} + {8'b0, c ^ o};
    r.s    = t[7:0] & mask;
    r.cout = t[w] ^ o;
    r.ovf  = (x[w-1] == yy[w-1]) && (r.s[w-1] != x[w-1]);
    r.zero = (r.s == 8'h00);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic op8_start(input logic o, input logic c, input logic [7:0] x, input logic [7:0] y);
    int n;
    n = 0;
    while (!ready8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", ready8, 1);
    start8 = 1'b1; op8 = o; cin8 = c; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic op8_wait_done(output int lat);
    lat = 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 4) begin
        chk("run_s_hidden", s8, 0);
        chk("run_not_ready", ready8, 0);
      end
    end
  endtask

  initial begin
    vec_t vecs[9];
    int lat, dones, ndone, idx, cyc, last_done;
    logic [7:0] cap_s;
    logic [9:0] iv;
    res_t exp_r, got_r;
    res_t expq[$];

    vecs[0] = '{OP_SUB, 1'b0, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{OP_SUB, 1'b0, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{OP_SUB, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{OP_ADD, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{OP_ADD, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{OP_SUB, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{OP_ADD, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{OP_SUB, 1'b0, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{OP_ADD, 1'b1, 8'h12, 8'h34, 8'h47, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", ready8, 1);
    chk("rst_done", done8, 0);
    chk("rst_s", s8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_zero", zero8, 0);

    for (int i = 0; i < 9; i++) begin
      op8_start(vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b);
      op8_wait_done(lat);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_s", i), s8, vecs[i].s);
      chk($sformatf("vec%0d_cout", i), cout8, vecs[i].cout);
      chk($sformatf("vec%0d_ovf", i), ovf8, vecs[i].ovf);
      chk($sformatf("vec%0d_zero", i), zero8, vecs[i].zero);
      @(negedge clk);
      chk($sformatf("vec%0d_ready_after", i), ready8, 1);
      chk($sformatf("vec%0d_done_single", i), done8, 0);
      chk($sformatf("vec%0d_s_held", i), s8, vecs[i].s);
    end

    // start pulsed and operands changed mid-RUN must not disturb the operation
    op8_start(OP_SUB, 1'b0, 8'h05, 8'h03);
    dones = 0;
    cap_s = 8'h00;
    for (int k = 0; k < 30; k++) begin
      if (done8) begin
        dones++;
        cap_s = s8;
      end
      if (k == 2) begin
        start8 = 1'b1; op8 = OP_ADD; cin8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end
      if (k == 5) start8 = 1'b0;
      @(negedge clk);
    end
    chk("midrun_done_count", dones, 1);
    chk("midrun_s", cap_s, 8'h02);
    chk("midrun_s_held", s8, 8'h02);

    // reset while bit 4 is being processed aborts with no done pulse
    op8_start(OP_ADD, 1'b1, 8'h12, 8'h34);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", ready8, 1);
    chk("abort_s", s8, 0);
    chk("abort_done", done8, 0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (done8) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", dones, 0);
    op8_start(OP_ADD, 1'b1, 8'h12, 8'h34);
    op8_wait_done(lat);
    chk("after_abort_latency", lat, 8);
    chk("after_abort_s", s8, 8'h47);

    // reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; op8 = OP_ADD; cin8 = 1'b0;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    chk("rst_over_start_ready", ready8, 1);
    @(negedge clk);
    chk("rst_over_start_idle", ready8, 1);

    // reset during DONE clears held flags
    op8_start(OP_ADD, 1'b1, 8'hFF, 8'h00);
    op8_wait_done(lat);
    chk("done_rst_pre_zero", zero8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("done_rst_cout", cout8, 0);
    chk("done_rst_zero", zero8, 0);
    chk("done_rst_done", done8, 0);
    chk("done_rst_ready", ready8, 1);

    // 4-bit exhaustive sweep with start held high
    ndone = 0; idx = 0; cyc = 0; last_done = -1;
    while (ndone < 1024 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (done4) begin
        got_r = '{{4'h0, s4}, cout4, ovf4, zero4};
        if (expq.size() > 0) begin
          exp_r = expq.pop_front();
          chk($sformatf("w4_op%0d_result", ndone), 32'(got_r), 32'(exp_r));
        end else begin
          chk("w4_unexpected_done", 1, 0);
        end
        if (last_done >= 0) chk("w4_done_spacing", cyc - last_done, 6);
        last_done = cyc;
        ndone++;
      end
      if (ready4) begin
        if (idx < 1024) begin
          iv = idx[9:0];
          a4 = iv[3:0]; b4 = iv[7:4]; cin4 = iv[8]; op4 = iv[9];
          start4 = 1'b1;
          expq.push_back(ref_model(4, iv[9], iv[8], {4'h0, iv[3:0]}, {4'h0, iv[7:4]}));
          idx++;
        end else begin
          start4 = 1'b0;
        end
      end
    end
    start4 = 1'b0;
    chk("w4_all_done", ndone, 1024);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
